// File: rtl/rr_reg_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_reg_arb_if
//  Description : Bundle of the requester side and the downstream side of
//                the round-robin register arbiter.
//                  req_valid [N_REQ]        per-requester valid
//                  req_data  [N_REQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//                  req_ready [N_REQ]        one-hot-or-zero accept
//                  out_valid / out_data / out_src / out_ready   held word
//                The slave modport is the arbiter's view. The master modport
//                is the view of the environment around it: the producers and
//                the consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_reg_arb_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SRC_W-1:0]       out_src;
    logic                   out_ready;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/rr_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_reg_arb
//  Description : Round-robin arbiter that shares one enabled output register
//                among N_REQ requesters. Each cycle the register is free
//                (empty or being drained), the first valid requester at or
//                above ptr (wrapping) is accepted. Its word is loaded together
//                with its index. The pointer then moves past the winner.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - rr_reg_arb_if.slave: requester valid/data/ready and
//                       downstream out_valid/out_data/out_src/out_ready
//  Options     : RR_ARB_PRIO0_EN - when defined, requester 0 has strict
//                priority and does not move ptr. The others rotate among
//                themselves and skip index 0.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_reg_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    rr_reg_arb_if.slave bus
);
    localparam int SRC_W = $clog2(N_REQ);

    // Pointer arithmetic uses one extra bit, so ptr + k (at most 2*N_REQ-2)
    // never overflows before the modulo correction.
    localparam logic [SRC_W:0]   c_N_EXT = (SRC_W+1)'(N_REQ);
    localparam logic [SRC_W-1:0] c_LAST  = SRC_W'(N_REQ - 1);

`ifdef RR_ARB_PRIO0_EN
    localparam bit c_PRIO0 = 1'b1;
`else
    localparam bit c_PRIO0 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SRC_W-1:0]   out_src_q,   out_src_d;
    logic [SRC_W-1:0]   ptr_q,       ptr_d;

    // ------------------------------------------------------------------
    // Grant search
    // ------------------------------------------------------------------
    logic               w_load;
    logic               w_found;
    logic               w_xfer;
    logic [SRC_W-1:0]   w_sel;
    logic [SRC_W:0]     w_idx;
    logic [N_REQ-1:0]   w_ready;

    assign w_load = !out_valid_q || bus.out_ready;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        // Strict-priority requester 0. w_sel already holds index 0.
        if (c_PRIO0 && bus.req_valid[0]) begin
            w_found = 1'b1;
        end
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (w_idx >= c_N_EXT) begin
                w_idx = w_idx - c_N_EXT;
            end
            if (!w_found && bus.req_valid[w_idx[SRC_W-1:0]] &&
                !(c_PRIO0 && (w_idx == '0))) begin
                w_found = 1'b1;
                w_sel   = w_idx[SRC_W-1:0];
            end
        end
    end

    // Reset blocks every handshake, so a cycle in reset never consumes a word.
    assign w_xfer = w_load && w_found && !rst;

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        // Valid stays set on a stall, is reloaded on a transfer, and clears
        // on a drain that has no replacement.
        out_valid_d = w_xfer || (out_valid_q && !bus.out_ready);
        if (w_xfer) begin
            out_data_d = bus.req_data[int'(w_sel)*WIDTH +: WIDTH];
            out_src_d  = w_sel;
            if (!(c_PRIO0 && (w_sel == '0))) begin
                ptr_d = (w_sel == c_LAST) ? '0 : w_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_reg_arb
//  Description : Directed, self-checking bench for rr_reg_arb (N_REQ=4,
//                WIDTH=8). Inputs change 1 time unit after the rising edge.
//                Outputs are sampled at that same point, after settling.
//                Every expected value is written out by hand.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_reg_arb;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_reg_arb_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    rr_reg_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let the inputs and outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".src"},   32'(bus.out_src),   32'(s));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.out_ready = 1'b1;

`ifndef RR_ARB_PRIO0_EN
        // Reset held for 3 cycles while every requester is valid.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.ready", 32'(bus.req_ready), 32'h0);
            chk_out("rst", 1'b0, 8'h00, 2'd0);
        end
        rst = 1'b0;
        #1;
        chk("first.ready", 32'(bus.req_ready), 32'b0001);

        // All four valid: rotation 0,1,2,3,0 with continuous valid.
        step(); chk_out("rr0", 1'b1, 8'h11, 2'd0);
        chk("rr0.ready", 32'(bus.req_ready), 32'b0010);
        step(); chk_out("rr1", 1'b1, 8'h22, 2'd1);
        step(); chk_out("rr2", 1'b1, 8'h33, 2'd2);
        step(); chk_out("rr3", 1'b1, 8'h44, 2'd3);
        step(); chk_out("rr4", 1'b1, 8'h11, 2'd0);
        // ptr is now 1

        // Only req 2 valid with AB. Load it, then stall for 3 cycles.
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h44, 8'hAB, 8'h22, 8'h11};
        #1;
        chk("ld2.ready", 32'(bus.req_ready), 32'b0100);
        step(); chk_out("ld2", 1'b1, 8'hAB, 2'd2);
        bus.out_ready = 1'b0;
        bus.req_data  = {8'h44, 8'hAC, 8'h22, 8'h11};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.ready", 32'(bus.req_ready), 32'h0);
            step();
            chk_out("stall", 1'b1, 8'hAB, 2'd2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall.ready", 32'(bus.req_ready), 32'b0100);
        step(); chk_out("unstall", 1'b1, 8'hAC, 2'd2);
        // ptr is now 3

        // Only req 1 valid: accepted by wrap-around. ptr becomes 2.
        bus.req_valid = 4'b0010;
        #1;
        chk("wrap.ready", 32'(bus.req_ready), 32'b0010);
        step(); chk_out("wrap", 1'b1, 8'h22, 2'd1);
        bus.req_valid = 4'b0101;
        #1;
        chk("ptr2.ready", 32'(bus.req_ready), 32'b0100);
        step(); chk_out("ptr2", 1'b1, 8'hAC, 2'd2);
        // ptr is now 3

        // Drain with nothing waiting: valid drops and the data holds.
        bus.req_valid = 4'b0000;
        #1;
        chk("drain.ready", 32'(bus.req_ready), 32'h0);
        step(); chk_out("drain", 1'b0, 8'hAC, 2'd2);

        // Load CD from req 0 (ptr 3 wraps to 0), then reset while it is held.
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'hCD};
        step(); chk_out("ldCD", 1'b1, 8'hCD, 2'd0);
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        chk("midrst.ready", 32'(bus.req_ready), 32'h0);
        step(); chk_out("midrst", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        // Before reset ptr was 1. Reset must return it to 0.
        chk("postrst.ready", 32'(bus.req_ready), 32'b0001);
        step(); chk_out("postrst", 1'b1, 8'h11, 2'd0);
`else
        // Strict priority for requester 0.
        step();
        chk("rst.ready", 32'(bus.req_ready), 32'h0);
        chk_out("rst", 1'b0, 8'h00, 2'd0);
        rst           = 1'b0;
        bus.req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("prio0", 1'b1, 8'h11, 2'd0);
        end
        bus.req_valid = 4'b1000;
        #1;
        chk("drop0.ready", 32'(bus.req_ready), 32'b1000);
        step(); chk_out("drop0", 1'b1, 8'h44, 2'd3);
        // ptr is now 0. Requester 0 is skipped, so req 1 wins over req 3.
        bus.req_valid = 4'b1010;
        step(); chk_out("skip0", 1'b1, 8'h22, 2'd1);
        bus.req_valid = 4'b1011;
        step(); chk_out("prio0b", 1'b1, 8'h11, 2'd0);
        // The grant to 0 leaves ptr at 2, so req 3 beats req 1.
        bus.req_valid = 4'b1010;
        step(); chk_out("keepptr", 1'b1, 8'h44, 2'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rr_reg_arb.md
# rr_reg_arb

Round-robin arbiter sharing one enabled pipeline register among `N_REQ` requesters. Each cycle it picks one valid requester, drives the register's load enable and data, and presents the held word downstream with valid/ready handshaking. It sits in front of any single-stage enabled register stage where several producers feed one consumer. The block tags each output word with the index of the requester that produced it.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 8: data width.
- `SRC_W`, default `$clog2(N_REQ)`: width of the source tag (derived; do not override).

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester valid.
- `req_data`  in  N_REQ*WIDTH  requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  N_REQ  one-hot-or-zero; asserted for the requester accepted this cycle.
- `out_valid`  out  1  held word is valid.
- `out_data`  out  WIDTH  held word.
- `out_src`  out  SRC_W  index of the requester that produced `out_data`.
- `out_ready`  in  1  downstream accepts the word when `out_valid && out_ready`.

## Operation
- Output register: one entry holding `out_valid`, `out_data`, `out_src`.
- Load condition: `load = !out_valid || out_ready`, i.e. the register is empty or being drained this cycle.
- Grant: when `load` is true, grant the first requester with `req_valid` set, searching upward from `ptr` and wrapping from N_REQ-1 to 0. With no valid requester, there is no grant.
- `req_ready[i] = load && grant[i]`, combinational from `req_valid`, `ptr`, `out_valid` and `out_ready`. `req_ready` must never depend on itself.
- Transfer from requester i occurs on `req_valid[i] && req_ready[i]`. At the next edge:
  - `out_data <= req_data[i]`
  - `out_src <= i`
  - `out_valid <= 1`
  - `ptr <= (i+1) mod N_REQ`
- Drain with no grant: `out_valid <= 0`. `out_data` and `out_src` hold their values (don't-care for consumers).
- Stall (`out_valid && !out_ready`): the register holds, all `req_ready` are 0, and `ptr` holds.
- Simultaneous drain and grant: the new word replaces the old word in the same edge, so throughput is 1 word per cycle.
- `ptr` changes only on a transfer.
- Requesters may drop `req_valid` without a transfer. The arbiter stores no request state.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=0`. During `rst`, all `req_ready` are 0.
- Latency: a word accepted at edge k is visible on `out_*` after edge k, i.e. 1 cycle.
- Back-to-back: with `out_ready` held at 1 and at least one valid requester every cycle, `out_valid` stays 1 and a new word arrives every cycle.
- Fairness: with all N_REQ requesters continuously valid and `out_ready=1`, grants rotate 0,1,…,N_REQ-1,0,… The maximum wait is N_REQ-1 transfers.
- Reset mid-operation: the held word is discarded, `ptr` returns to 0, and any handshake in that cycle is ignored.
- `out_data`, `out_src` and `out_valid` come directly from flops. The combinational path from `out_ready` to `req_ready` is permitted.

## Configuration
- `RR_ARB_PRIO0_EN`, defined:
  - Requester 0 has strict priority and wins whenever `req_valid[0]` is set and `load` is true.
  - A grant to requester 0 leaves `ptr` unchanged.
  - Other requesters arbitrate round-robin among themselves using `ptr`, skipping index 0.
- `RR_ARB_PRIO0_EN`, undefined: pure round-robin as described above.
- Interface and latency are identical in both builds.

## Test plan
All scenarios use N_REQ=4, WIDTH=8, without `RR_ARB_PRIO0_EN` unless stated.

1. Reset held 3 cycles with all `req_valid=1` → `req_ready=0000`, `out_valid=0`, `out_data=00`, `out_src=0` throughout. First post-reset grant goes to req 0.
2. All four valid with data 11/22/33/44 and `out_ready=1` → `out_src` sequence 0,1,2,3,0, `out_data` 11,22,33,44,11, `out_valid` continuously 1.
3. Only req 2 valid with data AB, `out_ready=0` for 3 cycles after the first load → `out_data=AB`, `out_valid=1` held and `req_ready=0000` during the stall. `out_ready=1` then accepts the next word from req 2 in the same cycle.
4. `ptr=3` and only req 1 valid → grant to req 1 via wrap-around, after which `ptr=2`. Then reqs 0 and 2 both valid → req 2 wins.
5. Word CD held with `out_valid=1` and `rst` asserted for 1 cycle → after the edge `out_valid=0`, `out_data=00`, `ptr=0`. CD is never accepted downstream.
6. With `RR_ARB_PRIO0_EN`: reqs 0 and 3 continuously valid, `out_ready=1` → `out_src` always 0. Dropping req 0 → next word comes from req 3.
